pcie_req_scheduler: RTL and testbench

Shares the single endpoint request port among NUM_REQ upstream requesters using round-robin arbitration. Each forwarded MRd gets a unique tag from a local pool. Each completion is routed back to the requester that issued the read, with that requester's original tag restored. The block sits between the host-side traffic sources and the endpoint's req/cpl TLP streams.

---
 rtl/pcie_req_scheduler.sv | 217 +++++++++++++++++++++
 tb/tb_pcie_req_scheduler.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_req_scheduler.sv
// Round-robin request scheduler for a shared PCIe endpoint request port.
// Remaps MRd tags from a local pool and routes completions back to their issuers.
module pcie_req_scheduler #(
  parameter int NUM_REQ  = 4,
  parameter int NUM_TAGS = 8
) (
  input  logic                   PCIE_CLK,
  input  logic                   PCIE_RSTn,
  input  logic [NUM_REQ-1:0]     up_req_valid,
  output logic [NUM_REQ-1:0]     up_req_ready,
  input  logic [NUM_REQ*128-1:0] up_req_tlp,
  output logic                   req_valid,
  input  logic                   req_ready,
  output logic [127:0]           req_tlp,
  input  logic                   cpl_valid,
  output logic                   cpl_ready,
  input  logic [127:0]           cpl_tlp,
  output logic [NUM_REQ-1:0]     up_cpl_valid,
  input  logic [NUM_REQ-1:0]     up_cpl_ready,
  output logic [127:0]           up_cpl_tlp,
  output logic [4:0]             tags_outstanding,
  output logic                   err_unexp_cpl
);

  localparam logic [7:0] TYPE_MRD = 8'h01;

  logic [2:0]          rr_ptr_r;
  logic [NUM_TAGS-1:0] tag_alloc_r;
  logic [2:0]          tag_owner_r [NUM_TAGS];
  logic [7:0]          tag_orig_r  [NUM_TAGS];
  logic [4:0]          tag_cnt_r;

  logic                can_load_s;
  logic                free_any_s;
  logic [3:0]          free_tag_s;
  logic [NUM_REQ-1:0]  eligible_s;
  logic [NUM_REQ-1:0]  rot_s;
  logic                grant_found_s;
  logic [3:0]          grant_sum_s;
  logic [2:0]          grant_idx_s;
  logic [127:0]        grant_tlp_s;
  logic [127:0]        fwd_tlp_s;
  logic                grant_fire_s;
  logic                alloc_s;

  logic [7:0]          cpl_tag_s;
  logic                cpl_hit_s;
  logic [3:0]          cpl_idx_s;
  logic [2:0]          cpl_owner_s;
  logic [7:0]          cpl_orig_s;
  logic                cpl_free_s;
  logic                cpl_err_s;

  assign tags_outstanding = tag_cnt_r;

  // Arbitration: lowest free tag, eligibility, rotated priority search and TLP selection
  always_comb begin
    can_load_s = !req_valid || req_ready;

    free_any_s = 1'b0;
    free_tag_s = 4'd0;
    for (int t = NUM_TAGS - 1; t >= 0; t--) begin
      if (!tag_alloc_r[t]) begin
        free_any_s = 1'b1;
        free_tag_s = 4'(t);
      end else begin
        free_any_s = free_any_s;
      end
    end

    for (int i = 0; i < NUM_REQ; i++) begin
      eligible_s[i] = up_req_valid[i] &&
                      ((up_req_tlp[i*128+120 +: 8] != TYPE_MRD) || free_any_s);
    end

    // Rotate so bit 0 is the requester at the RR pointer
    rot_s = NUM_REQ'({eligible_s, eligible_s} >> rr_ptr_r);

    grant_found_s = 1'b0;
    grant_sum_s   = 4'd0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot_s[k]) begin
        grant_found_s = 1'b1;
        grant_sum_s   = {1'b0, rr_ptr_r} + 4'(k);
      end else begin
        grant_found_s = grant_found_s;
      end
    end
    if (grant_sum_s >= 4'(NUM_REQ)) begin
      grant_idx_s = 3'(grant_sum_s - 4'(NUM_REQ));
    end else begin
      grant_idx_s = 3'(grant_sum_s);
    end

    grant_tlp_s = 128'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx_s == 3'(i)) begin
        grant_tlp_s = up_req_tlp[i*128 +: 128];
      end else begin
        grant_tlp_s = grant_tlp_s;
      end
    end

    fwd_tlp_s = grant_tlp_s;
    if (grant_tlp_s[127:120] == TYPE_MRD) begin
      fwd_tlp_s[79:72] = {4'd0, free_tag_s};
    end else begin
      fwd_tlp_s[79:72] = grant_tlp_s[79:72];
    end

    grant_fire_s = can_load_s && grant_found_s;
    alloc_s      = grant_fire_s && (grant_tlp_s[127:120] == TYPE_MRD);

    for (int i = 0; i < NUM_REQ; i++) begin
      up_req_ready[i] = grant_fire_s && (grant_idx_s == 3'(i));
    end
  end

  // Completion lookup and routing back to the owning requester
  always_comb begin
    cpl_tag_s   = cpl_tlp[79:72];
    cpl_hit_s   = 1'b0;
    cpl_idx_s   = 4'd0;
    cpl_owner_s = 3'd0;
    cpl_orig_s  = 8'd0;
    for (int t = 0; t < NUM_TAGS; t++) begin
      if ((cpl_tag_s == 8'(t)) && tag_alloc_r[t]) begin
        cpl_hit_s   = 1'b1;
        cpl_idx_s   = 4'(t);
        cpl_owner_s = tag_owner_r[t];
        cpl_orig_s  = tag_orig_r[t];
      end else begin
        cpl_hit_s = cpl_hit_s;
      end
    end

    up_cpl_tlp   = cpl_tlp;
    up_cpl_valid = '0;
    cpl_ready    = 1'b1;
    if (cpl_hit_s) begin
      up_cpl_tlp[79:72] = cpl_orig_s;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (cpl_owner_s == 3'(i)) begin
          up_cpl_valid[i] = cpl_valid;
          cpl_ready       = up_cpl_ready[i];
        end else begin
          up_cpl_valid[i] = 1'b0;
        end
      end
    end else begin
      // Unknown tag: swallow it so the endpoint stream never stalls
      up_cpl_tlp[79:72] = cpl_tag_s;
    end

    cpl_free_s = cpl_valid && cpl_ready && cpl_hit_s;
    cpl_err_s  = cpl_valid && !cpl_hit_s;
  end

  // Output stage, RR pointer, tag table, outstanding counter and error pulse
  always_ff @(posedge PCIE_CLK or negedge PCIE_RSTn) begin
    if (!PCIE_RSTn) begin
      req_valid     <= 1'b0;
      req_tlp       <= 128'd0;
      rr_ptr_r      <= 3'd0;
      tag_alloc_r   <= '0;
      tag_cnt_r     <= 5'd0;
      err_unexp_cpl <= 1'b0;
      for (int t = 0; t < NUM_TAGS; t++) begin
        tag_owner_r[t] <= 3'd0;
        tag_orig_r[t]  <= 8'd0;
      end
    end else begin
      err_unexp_cpl <= cpl_err_s;

      if (can_load_s) begin
        req_valid <= grant_found_s;
        if (grant_found_s) begin
          req_tlp <= fwd_tlp_s;
        end else begin
          req_tlp <= req_tlp;
        end
      end else begin
        req_valid <= req_valid;
      end

      if (grant_fire_s) begin
        if (grant_idx_s == 3'(NUM_REQ - 1)) begin
          rr_ptr_r <= 3'd0;
        end else begin
          rr_ptr_r <= grant_idx_s + 3'd1;
        end
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end

      // The allocated tag was free this cycle, so it never collides with the freed one
      for (int t = 0; t < NUM_TAGS; t++) begin
        if (alloc_s && (free_tag_s == 4'(t))) begin
          tag_alloc_r[t] <= 1'b1;
          tag_owner_r[t] <= grant_idx_s;
          tag_orig_r[t]  <= grant_tlp_s[79:72];
        end else if (cpl_free_s && (cpl_idx_s == 4'(t))) begin
          tag_alloc_r[t] <= 1'b0;
        end else begin
          tag_alloc_r[t] <= tag_alloc_r[t];
        end
      end

      case ({alloc_s, cpl_free_s})
        2'b10:   tag_cnt_r <= tag_cnt_r + 5'd1;
        2'b01:   tag_cnt_r <= tag_cnt_r - 5'd1;
        default: tag_cnt_r <= tag_cnt_r;
      endcase
    end
  end

endmodule

// File: tb/tb_pcie_req_scheduler.sv
// Directed bench for pcie_req_scheduler: stimulus pushes expected TLPs into
// queues, negedge monitors pop and compare on each output handshake.
module tb_pcie_req_scheduler;

  localparam int NR = 4;
  localparam int NT = 8;

  logic              PCIE_CLK = 1'b0;
  logic              PCIE_RSTn;
  logic [NR-1:0]     up_req_valid;
  logic [NR-1:0]     up_req_ready;
  logic [NR*128-1:0] up_req_tlp;
  logic              req_valid;
  logic              req_ready;
  logic [127:0]      req_tlp;
  logic              cpl_valid;
  logic              cpl_ready;
  logic [127:0]      cpl_tlp;
  logic [NR-1:0]     up_cpl_valid;
  logic [NR-1:0]     up_cpl_ready;
  logic [127:0]      up_cpl_tlp;
  logic [4:0]        tags_outstanding;
  logic              err_unexp_cpl;

  pcie_req_scheduler #(.NUM_REQ(NR), .NUM_TAGS(NT)) dut (
    .PCIE_CLK        (PCIE_CLK),
    .PCIE_RSTn       (PCIE_RSTn),
    .up_req_valid    (up_req_valid),
    .up_req_ready    (up_req_ready),
    .up_req_tlp      (up_req_tlp),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_tlp         (req_tlp),
    .cpl_valid       (cpl_valid),
    .cpl_ready       (cpl_ready),
    .cpl_tlp         (cpl_tlp),
    .up_cpl_valid    (up_cpl_valid),
    .up_cpl_ready    (up_cpl_ready),
    .up_cpl_tlp      (up_cpl_tlp),
    .tags_outstanding(tags_outstanding),
    .err_unexp_cpl   (err_unexp_cpl)
  );

  always #5 PCIE_CLK = ~PCIE_CLK;

  typedef struct packed {
    logic [NR-1:0] mask;
    logic [127:0]  tlp;
  } cpl_exp_t;

  int           n_checks   = 0;
  int           n_err      = 0;
  int           err_pulses = 0;
  logic [127:0] exp_req_q[$];
  cpl_exp_t     exp_cpl_q[$];
  logic [127:0] mon_req_e;
  cpl_exp_t     mon_cpl_e;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] mk(input logic [7:0] ty, input logic [7:0] tg, input logic [31:0] id);
    return {ty, 8'hA5, id, tg, 40'h0, id};
  endfunction

  task automatic set_req(input int i, input logic [127:0] t);
    up_req_tlp[i*128 +: 128] = t;
    up_req_valid[i] = 1'b1;
  endtask

  task automatic step();
    @(posedge PCIE_CLK);
    #1;
  endtask

  task automatic push_cpl(input logic [NR-1:0] m, input logic [127:0] t);
    cpl_exp_t e;
    e.mask = m;
    e.tlp  = t;
    exp_cpl_q.push_back(e);
  endtask

  // Request-side monitor
  always @(negedge PCIE_CLK) begin
    if (PCIE_RSTn && req_valid && req_ready) begin
      if (exp_req_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL req_unexpected: got %h expected none", req_tlp);
      end else begin
        mon_req_e = exp_req_q.pop_front();
        chk("req_tlp", req_tlp, mon_req_e);
      end
    end
  end

  // Completion-side monitor
  always @(negedge PCIE_CLK) begin
    if (PCIE_RSTn && ((up_cpl_valid & up_cpl_ready) != '0)) begin
      if (exp_cpl_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL cpl_unexpected: got %b expected none", up_cpl_valid);
      end else begin
        mon_cpl_e = exp_cpl_q.pop_front();
        chk("up_cpl_valid", {124'd0, up_cpl_valid}, {124'd0, mon_cpl_e.mask});
        chk("up_cpl_tlp", up_cpl_tlp, mon_cpl_e.tlp);
      end
    end
  end

  // Error pulse counter
  always @(negedge PCIE_CLK) begin
    if (err_unexp_cpl) err_pulses++;
  end

  initial begin
    logic [127:0] ta, tb_, tc;
    PCIE_RSTn    = 1'b0;
    up_req_valid = '0;
    up_req_tlp   = '0;
    req_ready    = 1'b0;
    cpl_valid    = 1'b0;
    cpl_tlp      = '0;
    up_cpl_ready = '0;

    @(negedge PCIE_CLK);
    chk("rst_req_valid", {127'd0, req_valid}, 128'd0);
    chk("rst_req_tlp", req_tlp, 128'd0);
    chk("rst_tags", {123'd0, tags_outstanding}, 128'd0);
    chk("rst_err", {127'd0, err_unexp_cpl}, 128'd0);
    repeat (2) @(posedge PCIE_CLK);
    #1 PCIE_RSTn = 1'b1;

    // Four simultaneous writes drain in RR order 0..3
    req_ready = 1'b1;
    for (int i = 0; i < NR; i++) begin
      set_req(i, mk(8'h00, 8'(i), 32'h100 + i));
      exp_req_q.push_back(mk(8'h00, 8'(i), 32'h100 + i));
    end
    for (int i = 0; i < NR; i++) begin
      @(negedge PCIE_CLK);
      chk("s1_grant", {124'd0, up_req_ready}, {124'd0, 4'b0001 << i});
      step();
      up_req_valid[i] = 1'b0;
    end
    @(negedge PCIE_CLK);
    chk("s1_tags", {123'd0, tags_outstanding}, 128'd0);
    step();

    // Single MRd round trip with tag remap and restore
    set_req(2, mk(8'h01, 8'h55, 32'h200));
    exp_req_q.push_back(mk(8'h01, 8'h00, 32'h200));
    @(negedge PCIE_CLK);
    chk("s2_grant", {124'd0, up_req_ready}, {124'd0, 4'b0100});
    step();
    up_req_valid[2] = 1'b0;
    @(negedge PCIE_CLK);
    chk("s2_tags_alloc", {123'd0, tags_outstanding}, 128'd1);
    step();
    cpl_tlp      = mk(8'h4A, 8'h00, 32'h2C0);
    cpl_valid    = 1'b1;
    up_cpl_ready = 4'hF;
    push_cpl(4'b0100, mk(8'h4A, 8'h55, 32'h2C0));
    @(negedge PCIE_CLK);
    chk("s2_tags_hold", {123'd0, tags_outstanding}, 128'd1);
    step();
    cpl_valid = 1'b0;
    @(negedge PCIE_CLK);
    chk("s2_tags_free", {123'd0, tags_outstanding}, 128'd0);
    step();

    // Fill the pool from requester 0
    for (int k = 0; k < NT; k++) begin
      set_req(0, mk(8'h01, 8'h10 + 8'(k), 32'h300 + k));
      exp_req_q.push_back(mk(8'h01, 8'(k), 32'h300 + k));
      @(negedge PCIE_CLK);
      chk("s3_fill_grant", {124'd0, up_req_ready}, {124'd0, 4'b0001});
      step();
    end
    up_req_valid[0] = 1'b0;
    @(negedge PCIE_CLK);
    chk("s3_tags_full", {123'd0, tags_outstanding}, 128'd8);
    step();

    // Pool full: req1 MRd skipped, req3 MWr passes
    set_req(1, mk(8'h01, 8'h21, 32'h400));
    set_req(3, mk(8'h00, 8'h33, 32'h401));
    exp_req_q.push_back(mk(8'h00, 8'h33, 32'h401));
    @(negedge PCIE_CLK);
    chk("s3_skip_grant", {124'd0, up_req_ready}, {124'd0, 4'b1000});
    step();
    up_req_valid[3] = 1'b0;
    @(negedge PCIE_CLK);
    chk("s3_stalled", {124'd0, up_req_ready}, 128'd0);
    chk("s3_tags_stall", {123'd0, tags_outstanding}, 128'd8);
    step();
    cpl_tlp   = mk(8'h4A, 8'h05, 32'h4C5);
    cpl_valid = 1'b1;
    push_cpl(4'b0001, mk(8'h4A, 8'h15, 32'h4C5));
    @(negedge PCIE_CLK);
    chk("s3_no_reuse", {124'd0, up_req_ready}, 128'd0);
    step();
    cpl_valid = 1'b0;
    exp_req_q.push_back(mk(8'h01, 8'h05, 32'h400));
    @(negedge PCIE_CLK);
    chk("s3_reuse_grant", {124'd0, up_req_ready}, {124'd0, 4'b0010});
    chk("s3_tags_7", {123'd0, tags_outstanding}, 128'd7);
    step();
    up_req_valid[1] = 1'b0;
    @(negedge PCIE_CLK);
    chk("s3_tags_8", {123'd0, tags_outstanding}, 128'd8);
    step();

    // Return every outstanding tag
    for (int k = 0; k < NT; k++) begin
      cpl_tlp   = mk(8'h4A, 8'(k), 32'h500 + k);
      cpl_valid = 1'b1;
      if (k == 5) push_cpl(4'b0010, mk(8'h4A, 8'h21, 32'h500 + k));
      else        push_cpl(4'b0001, mk(8'h4A, 8'h10 + 8'(k), 32'h500 + k));
      step();
    end
    cpl_valid = 1'b0;
    @(negedge PCIE_CLK);
    chk("s3_tags_drained", {123'd0, tags_outstanding}, 128'd0);
    step();

    // Backpressure: stage holds A, then A, C, B one per cycle
    req_ready = 1'b0;
    ta  = mk(8'h00, 8'h41, 32'h600);
    tb_ = mk(8'h00, 8'h42, 32'h601);
    tc  = mk(8'h00, 8'h43, 32'h602);
    set_req(0, ta);
    exp_req_q.push_back(ta);
    @(negedge PCIE_CLK);
    chk("s4_first_grant", {124'd0, up_req_ready}, {124'd0, 4'b0001});
    step();
    set_req(0, tb_);
    set_req(1, tc);
    for (int c = 0; c < 4; c++) begin
      @(negedge PCIE_CLK);
      chk("s4_hold_valid", {127'd0, req_valid}, 128'd1);
      chk("s4_hold_tlp", req_tlp, ta);
      chk("s4_hold_ready", {124'd0, up_req_ready}, 128'd0);
      step();
    end
    req_ready = 1'b1;
    exp_req_q.push_back(tc);
    @(negedge PCIE_CLK);
    chk("s4_resume_grant1", {124'd0, up_req_ready}, {124'd0, 4'b0010});
    chk("s4_stream_a", {127'd0, req_valid}, 128'd1);
    step();
    up_req_valid[1] = 1'b0;
    exp_req_q.push_back(tb_);
    @(negedge PCIE_CLK);
    chk("s4_resume_grant0", {124'd0, up_req_ready}, {124'd0, 4'b0001});
    chk("s4_stream_c", {127'd0, req_valid}, 128'd1);
    step();
    up_req_valid[0] = 1'b0;
    @(negedge PCIE_CLK);
    chk("s4_stream_b", {127'd0, req_valid}, 128'd1);
    step();
    @(negedge PCIE_CLK);
    chk("s4_empty", {127'd0, req_valid}, 128'd0);
    step();

    // Unallocated completion tag is dropped and flagged
    cpl_tlp      = mk(8'h4A, 8'h0C, 32'h700);
    cpl_valid    = 1'b1;
    up_cpl_ready = 4'h0;
    @(negedge PCIE_CLK);
    chk("s5_cpl_ready", {127'd0, cpl_ready}, 128'd1);
    chk("s5_no_route", {124'd0, up_cpl_valid}, 128'd0);
    chk("s5_err_early", {127'd0, err_unexp_cpl}, 128'd0);
    step();
    cpl_valid = 1'b0;
    @(negedge PCIE_CLK);
    chk("s5_err_pulse", {127'd0, err_unexp_cpl}, 128'd1);
    step();
    @(negedge PCIE_CLK);
    chk("s5_err_clear", {127'd0, err_unexp_cpl}, 128'd0);
    step();

    // Reset with three tags outstanding and a held request
    up_cpl_ready = 4'hF;
    set_req(0, mk(8'h01, 8'h30, 32'h800));
    exp_req_q.push_back(mk(8'h01, 8'h00, 32'h800));
    step();
    set_req(0, mk(8'h01, 8'h31, 32'h801));
    exp_req_q.push_back(mk(8'h01, 8'h01, 32'h801));
    step();
    set_req(0, mk(8'h01, 8'h32, 32'h802));
    step();
    up_req_valid[0] = 1'b0;
    req_ready = 1'b0;
    @(negedge PCIE_CLK);
    chk("s6_held_valid", {127'd0, req_valid}, 128'd1);
    chk("s6_held_tlp", req_tlp, mk(8'h01, 8'h02, 32'h802));
    chk("s6_tags_3", {123'd0, tags_outstanding}, 128'd3);
    #2 PCIE_RSTn = 1'b0;
    #1;
    chk("s6_rst_valid", {127'd0, req_valid}, 128'd0);
    chk("s6_rst_tags", {123'd0, tags_outstanding}, 128'd0);
    step();
    PCIE_RSTn = 1'b1;
    step();
    cpl_tlp   = mk(8'h4A, 8'h00, 32'h900);
    cpl_valid = 1'b1;
    @(negedge PCIE_CLK);
    chk("s6_old_no_route", {124'd0, up_cpl_valid}, 128'd0);
    chk("s6_old_cpl_ready", {127'd0, cpl_ready}, 128'd1);
    step();
    cpl_valid = 1'b0;
    @(negedge PCIE_CLK);
    chk("s6_old_err", {127'd0, err_unexp_cpl}, 128'd1);
    step();
    repeat (2) step();

    chk("req_q_empty", 128'(exp_req_q.size()), 128'd0);
    chk("cpl_q_empty", 128'(exp_cpl_q.size()), 128'd0);
    chk("err_pulse_count", 128'(err_pulses), 128'd2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
